// File: rtl/fifo_ptr_pkg.sv
// Shared pointer helpers for the async FIFO write/read pointer blocks.
// Functions work on a fixed maximum width; callers cast in and out.
package fifo_ptr_pkg;

   localparam int ADDR_W_DEF = 4;
   localparam int PTR_MAX_W  = 16;

   typedef logic [PTR_MAX_W-1:0] ptr_t;

   function automatic ptr_t bin2gray(input ptr_t bin);
      return bin ^ (bin >> 1);
   endfunction

   // Prefix XOR from the MSB down; zero-extended upper bits are harmless.
   function automatic ptr_t gray2bin(input ptr_t gray);
      ptr_t b;
      b[PTR_MAX_W-1] = gray[PTR_MAX_W-1];
      for (int i = PTR_MAX_W-2; i >= 0; i--)
         b[i] = b[i+1] ^ gray[i];
      return b;
   endfunction

   // Full when the write pointer is one lap ahead: top two Gray bits differ.
   function automatic logic full_match(input ptr_t gray_next, input ptr_t rgray,
                                       input int w);
      ptr_t mask;
      mask        = '0;
      mask[w-1]   = 1'b1;
      mask[w-2]   = 1'b1;
      return gray_next == (rgray ^ mask);
   endfunction

endpackage

// File: rtl/gray_ptr_ctr.sv
// Binary pointer counter with a registered Gray copy for clock crossing.
// Shared by the write-full and read-empty pointer generators.
module gray_ptr_ctr
   import fifo_ptr_pkg::*;
#(
   parameter int W = 5
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         inc,
   output logic [W-1:0] bin,
   output logic [W-1:0] gray,
   output logic [W-1:0] gray_next
);

   logic [W-1:0] bin_next;

   always_comb begin
      bin_next  = bin + W'(inc);
      gray_next = W'(bin2gray(PTR_MAX_W'(bin_next)));
   end

   // Gray output comes straight from a flop so the crossing sees one-bit steps.
   always_ff @(posedge clk) begin
      if (rst) begin
         bin  <= '0;
         gray <= '0;
      end else begin
         bin  <= bin_next;
         gray <= gray_next;
      end
   end

endmodule

// File: rtl/gray_wptr_full.sv
// Write-side pointer, RAM address and registered FULL flag for the async FIFO.
// Optional almost-full flag enabled with GRAY_WPTR_ALMOST_FULL_EN.
module gray_wptr_full
   import fifo_ptr_pkg::*;
#(
   parameter int ADDR_W   = ADDR_W_DEF,
   parameter int AF_LEVEL = 12
) (
   input  logic              CLK_i,
   input  logic              RST_i,
   input  logic              WINC_i,
   input  logic [ADDR_W:0]   RGRAY_SYNC_i,
   output logic [ADDR_W-1:0] WADDR_o,
   output logic [ADDR_W:0]   WGRAY_o,
   output logic              FULL_o,
   output logic              ALMOST_FULL_o
);

   localparam int PW = ADDR_W + 1;

   logic          push;
   logic          full_next;
   logic [PW-1:0] bin;
   logic [PW-1:0] gray_next;

   assign push = WINC_i & ~FULL_o;

   gray_ptr_ctr #(.W(PW)) u_ctr (
      .clk       (CLK_i),
      .rst       (RST_i),
      .inc       (push),
      .bin       (bin),
      .gray      (WGRAY_o),
      .gray_next (gray_next)
   );

   assign WADDR_o   = bin[ADDR_W-1:0];
   assign full_next = full_match(PTR_MAX_W'(gray_next), PTR_MAX_W'(RGRAY_SYNC_i), PW);

   always_ff @(posedge CLK_i) begin
      if (RST_i) FULL_o <= 1'b0;
      else       FULL_o <= full_next;
   end

`ifdef GRAY_WPTR_ALMOST_FULL_EN
   logic [PW-1:0] rbin;
   logic [PW-1:0] level_next;

   assign rbin       = PW'(gray2bin(PTR_MAX_W'(RGRAY_SYNC_i)));
   assign level_next = bin + PW'(push) - rbin;

   always_ff @(posedge CLK_i) begin
      if (RST_i) ALMOST_FULL_o <= 1'b0;
      else       ALMOST_FULL_o <= (level_next >= PW'(AF_LEVEL));
   end
`else
   assign ALMOST_FULL_o = 1'b0;
`endif

endmodule

// File: tb/tb_gray_wptr_full.sv
// Scoreboard bench for gray_wptr_full at ADDR_W=4.
module tb_gray_wptr_full;

   typedef struct packed {
      logic [3:0] waddr;
      logic [4:0] wgray;
      logic       full;
      logic       af;
   } exp_t;

   logic       CLK_i = 1'b0;
   logic       RST_i = 1'b0;
   logic       WINC_i = 1'b0;
   logic [4:0] RGRAY_SYNC_i = '0;
   logic [3:0] WADDR_o;
   logic [4:0] WGRAY_o;
   logic       FULL_o;
   logic       ALMOST_FULL_o;

   int checks = 0;
   int failures = 0;

   exp_t sb[$];
   exp_t obs, exp_v;

   logic [4:0] m_bin = '0;
   logic [4:0] m_gray = '0;
   logic       m_full = 1'b0;
   logic       m_af = 1'b0;

   gray_wptr_full #(.ADDR_W(4), .AF_LEVEL(12)) dut (
      .CLK_i         (CLK_i),
      .RST_i         (RST_i),
      .WINC_i        (WINC_i),
      .RGRAY_SYNC_i  (RGRAY_SYNC_i),
      .WADDR_o       (WADDR_o),
      .WGRAY_o       (WGRAY_o),
      .FULL_o        (FULL_o),
      .ALMOST_FULL_o (ALMOST_FULL_o)
   );

   always #5 CLK_i = ~CLK_i;

   function automatic logic [4:0] g2b(input logic [4:0] g);
      logic [4:0] b;
      b[4] = g[4];
      for (int i = 3; i >= 0; i--) b[i] = b[i+1] ^ g[i];
      return b;
   endfunction

   // Drive one cycle, advance the reference model, queue the expected outputs.
   task automatic cyc(input logic rst, input logic winc, input logic [4:0] rg);
      logic [4:0] nb, ng, lvl;
      RST_i = rst; WINC_i = winc; RGRAY_SYNC_i = rg;
      if (rst) begin
         m_bin = '0; m_gray = '0; m_full = 1'b0; m_af = 1'b0;
      end else begin
         nb  = m_bin + {4'd0, (winc & ~m_full)};
         ng  = nb ^ (nb >> 1);
         m_full = (ng == {~rg[4:3], rg[2:0]});
         lvl = nb - g2b(rg);
`ifdef GRAY_WPTR_ALMOST_FULL_EN
         m_af = (lvl >= 5'd12);
`else
         m_af = 1'b0;
`endif
         m_bin = nb; m_gray = ng;
      end
      sb.push_back({m_bin[3:0], m_gray, m_full, m_af});
      @(posedge CLK_i);
      #1;
      obs = {WADDR_o, WGRAY_o, FULL_o, ALMOST_FULL_o};
   endtask

   task automatic test_reset();
      for (int i = 0; i < 2; i++) begin
         cyc(1'b1, 1'b1, 5'b00000);
         exp_v = sb.pop_front(); checks++;
         if (obs !== exp_v || obs !== '0) begin
            failures++;
            $display("FAIL reset cyc%0d got=%h want=%h", i, obs, exp_v);
         end
      end
      for (int i = 0; i < 3; i++) begin
         cyc(1'b0, 1'b1, 5'b00000);
         exp_v = sb.pop_front(); checks++;
         if (obs !== exp_v) begin
            failures++;
            $display("FAIL reset_pre_burst %0d got=%h want=%h", i, obs, exp_v);
         end
      end
      cyc(1'b1, 1'b1, 5'b00000);
      exp_v = sb.pop_front(); checks++;
      if (obs !== exp_v || obs !== '0) begin
         failures++;
         $display("FAIL reset_in_burst got=%h want=%h", obs, exp_v);
      end
   endtask

   task automatic test_single_push();
      cyc(1'b0, 1'b1, 5'b00000);
      exp_v = sb.pop_front(); checks++;
      if (obs !== exp_v || WADDR_o !== 4'd1 || WGRAY_o !== 5'b00001 || FULL_o !== 1'b0) begin
         failures++;
         $display("FAIL single_push got=%h want=%h", obs, exp_v);
      end
   endtask

   task automatic test_back_to_back();
      logic [4:0] seq [4] = '{5'b00001, 5'b00011, 5'b00010, 5'b00110};
      cyc(1'b1, 1'b0, 5'b00000);
      void'(sb.pop_front());
      for (int i = 0; i < 16; i++) begin
         cyc(1'b0, 1'b1, 5'b00000);
         exp_v = sb.pop_front(); checks++;
         if (obs !== exp_v || FULL_o !== (i == 15)) begin
            failures++;
            $display("FAIL b2b push%0d got=%h want=%h", i + 1, obs, exp_v);
         end
         if (i < 4) begin
            checks++;
            if (WGRAY_o !== seq[i]) begin
               failures++;
               $display("FAIL b2b_gray%0d got=%b want=%b", i + 1, WGRAY_o, seq[i]);
            end
         end
      end
      checks++;
      if (WGRAY_o !== 5'b11000) begin
         failures++;
         $display("FAIL b2b_last_gray got=%b want=11000", WGRAY_o);
      end
      cyc(1'b0, 1'b1, 5'b00000);
      exp_v = sb.pop_front(); checks++;
      if (obs !== exp_v || WADDR_o !== 4'd0 || WGRAY_o !== 5'b11000 || FULL_o !== 1'b1) begin
         failures++;
         $display("FAIL push_while_full got=%h want=%h", obs, exp_v);
      end
   endtask

   task automatic test_drain();
      cyc(1'b0, 1'b0, 5'b00001);
      exp_v = sb.pop_front(); checks++;
      if (obs !== exp_v || FULL_o !== 1'b0) begin
         failures++;
         $display("FAIL drain_clear got=%h want=%h", obs, exp_v);
      end
      cyc(1'b0, 1'b1, 5'b00001);
      exp_v = sb.pop_front(); checks++;
      if (obs !== exp_v || WGRAY_o !== 5'b11001 || FULL_o !== 1'b1) begin
         failures++;
         $display("FAIL drain_refill got=%h want=%h", obs, exp_v);
      end
   endtask

   task automatic test_wrap();
      logic [4:0] prev, rb;
      cyc(1'b1, 1'b0, 5'b00000);
      void'(sb.pop_front());
      prev = WGRAY_o;
      for (int i = 0; i < 40; i++) begin
         rb = m_bin - 5'd2;
         cyc(1'b0, 1'b1, rb ^ (rb >> 1));
         exp_v = sb.pop_front(); checks++;
         if (obs !== exp_v || FULL_o !== 1'b0 || $countones(WGRAY_o ^ prev) != 1) begin
            failures++;
            $display("FAIL wrap push%0d got=%h want=%h prev_gray=%b", i + 1, obs, exp_v, prev);
         end
         if (i == 30 || i == 31) begin
            checks++;
            if (WGRAY_o !== ((i == 30) ? 5'b10000 : 5'b00000)) begin
               failures++;
               $display("FAIL wrap_point push%0d got=%b", i + 1, WGRAY_o);
            end
         end
         prev = WGRAY_o;
      end
   endtask

   task automatic test_almost_full();
      logic af_exp;
      cyc(1'b1, 1'b0, 5'b00000);
      void'(sb.pop_front());
      for (int i = 0; i < 12; i++) begin
         cyc(1'b0, 1'b1, 5'b00000);
         exp_v = sb.pop_front(); checks++;
`ifdef GRAY_WPTR_ALMOST_FULL_EN
         af_exp = (i == 11);
`else
         af_exp = 1'b0;
`endif
         if (obs !== exp_v || ALMOST_FULL_o !== af_exp) begin
            failures++;
            $display("FAIL almost_full push%0d got=%h want=%h", i + 1, obs, exp_v);
         end
      end
      cyc(1'b0, 1'b0, 5'b00011);
      exp_v = sb.pop_front(); checks++;
      if (obs !== exp_v || ALMOST_FULL_o !== 1'b0) begin
         failures++;
         $display("FAIL almost_full_release got=%h want=%h", obs, exp_v);
      end
   endtask

   initial begin
      @(posedge CLK_i);
      #1;
      test_reset();
      test_single_push();
      test_back_to_back();
      test_drain();
      test_wrap();
      test_almost_full();
      checks++;
      if (sb.size() != 0) begin
         failures++;
         $display("FAIL scoreboard_leftover got=%0d want=0", sb.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
